// File: rtl/trb_mem_port.sv
// trb_mem_port: memory-side responder for the trace logger.
// Owns the trace array, generates the access strobe and the read/write allow
// signals, services one logger write per strobe, and zeroes the array on reset
// or on request while holding the logger off.
// Optional feature: define TRB_MEM_PARITY_EN to store an even-parity bit per
// word and raise a sticky PARITY_ERR_O when a read word fails its check.

package dtb_pkg;
    localparam int TRB_DEPTH = 16;
    localparam int TRB_WIDTH = 8;
endpackage

module trb_mem_port
    import dtb_pkg::*;
#(
    parameter int TURN_DIV = 2
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         ENABLE_I,
    input  logic                         CLEAR_I,
    output logic                         RW_TURN_O,
    output logic                         WRITE_ALLOW_O,
    output logic                         READ_ALLOW_O,
    input  logic                         WRITE_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] WRITE_PTR_I,
    input  logic [TRB_WIDTH-1:0]         DMEM_I,
    input  logic [$clog2(TRB_DEPTH)-1:0] READ_PTR_I,
    output logic [TRB_WIDTH-1:0]         DMEM_O,
    output logic                         BUSY_O,
    output logic                         PARITY_ERR_O
);

    localparam int PTR_W = $clog2(TRB_DEPTH);
    localparam int CNT_W = $clog2(TURN_DIV);

    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(TRB_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURN_DIV - 1);

    // Two-state controller: zeroing sweep, then normal service.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

`ifdef TRB_MEM_PARITY_EN
    localparam int MEM_W = TRB_WIDTH + 1;
`else
    localparam int MEM_W = TRB_WIDTH;
`endif

    logic [0:0]           state;
    logic [PTR_W-1:0]     clr_addr;
    logic [CNT_W-1:0]     turn_cnt;
    logic                 rw_turn;
    logic [TRB_WIDTH-1:0] rd_data;
    logic [MEM_W-1:0]     mem [TRB_DEPTH];
    logic [MEM_W-1:0]     wr_word;
    logic                 in_run;
    logic                 log_write;

    assign in_run        = (state == ST_RUN);
    assign BUSY_O        = (state == ST_CLEAR);
    assign READ_ALLOW_O  = in_run;
    assign WRITE_ALLOW_O = in_run & ENABLE_I;
    assign RW_TURN_O     = rw_turn;
    assign DMEM_O        = rd_data;

    // A logger write lands only in a strobe slot while writes are allowed.
    assign log_write = rw_turn & WRITE_I & WRITE_ALLOW_O;

`ifdef TRB_MEM_PARITY_EN
    // Even parity: the stored bit makes the XOR of the whole word zero.
    assign wr_word = {^DMEM_I, DMEM_I};
`else
    assign wr_word = DMEM_I;
`endif

    // Sweep controller: reset or a clear request restarts the sweep at address 0.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (CLEAR_I) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_addr == LAST_ADDR) begin
                state    <= ST_RUN;
                clr_addr <= '0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // Turn counter and registered strobe: one pulse per TURN_DIV enabled RUN cycles.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            turn_cnt <= '0;
            rw_turn  <= 1'b0;
        end else if (CLEAR_I || (state == ST_CLEAR)) begin
            turn_cnt <= '0;
            rw_turn  <= 1'b0;
        end else if (ENABLE_I) begin
            rw_turn  <= (turn_cnt == LAST_TURN);
            turn_cnt <= (turn_cnt == LAST_TURN) ? '0 : turn_cnt + 1'b1;
        end else begin
            // Disabled: counter holds, no new strobes.
            rw_turn  <= 1'b0;
        end
    end

    // Array write port: sweep zeroes one word per cycle, otherwise logger writes.
    // NOTE: the array deliberately has no reset; it stays a plain RAM and is
    // made defined by the zeroing sweep that follows every reset.
    always_ff @(posedge CLK_I) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (log_write) begin
            mem[WRITE_PTR_I] <= wr_word;
        end
    end

    // Registered read: follows READ_PTR_I every RUN cycle, forced to zero while sweeping.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rd_data <= '0;
        end else if (state == ST_RUN) begin
            rd_data <= mem[READ_PTR_I][TRB_WIDTH-1:0];
        end else begin
            rd_data <= '0;
        end
    end

`ifdef TRB_MEM_PARITY_EN
    logic parity_err;

    // Sticky parity flag: set by any RUN read whose word XORs to 1, cleared by a sweep.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            parity_err <= 1'b0;
        end else if (CLEAR_I || (state == ST_CLEAR)) begin
            parity_err <= 1'b0;
        end else if (^mem[READ_PTR_I]) begin
            parity_err <= 1'b1;
        end
    end

    assign PARITY_ERR_O = parity_err;
`else
    assign PARITY_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_trb_mem_port.sv
// Self-checking bench for trb_mem_port (TRB_DEPTH=16, TRB_WIDTH=8, TURN_DIV=2).
// Reads are issued with their expected word pushed into a queue; a monitor
// pops and compares one cycle later when the read result is presented.
// Define TRB_MEM_PARITY_EN for both RTL and bench to exercise the parity path.

module tb_trb_mem_port;

    localparam int DEPTH = 16;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic       ENABLE_I;
    logic       CLEAR_I;
    logic       RW_TURN_O;
    logic       WRITE_ALLOW_O;
    logic       READ_ALLOW_O;
    logic       WRITE_I;
    logic [3:0] WRITE_PTR_I;
    logic [7:0] DMEM_I;
    logic [3:0] READ_PTR_I;
    logic [7:0] DMEM_O;
    logic       BUSY_O;
    logic       PARITY_ERR_O;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] ptr;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    exp_q[$];
    logic [7:0] model [DEPTH];
    logic       rd_issue = 1'b0;
    logic       rd_valid = 1'b0;

    trb_mem_port #(.TURN_DIV(2)) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .ENABLE_I     (ENABLE_I),
        .CLEAR_I      (CLEAR_I),
        .RW_TURN_O    (RW_TURN_O),
        .WRITE_ALLOW_O(WRITE_ALLOW_O),
        .READ_ALLOW_O (READ_ALLOW_O),
        .WRITE_I      (WRITE_I),
        .WRITE_PTR_I  (WRITE_PTR_I),
        .DMEM_I       (DMEM_I),
        .READ_PTR_I   (READ_PTR_I),
        .DMEM_O       (DMEM_O),
        .BUSY_O       (BUSY_O),
        .PARITY_ERR_O (PARITY_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK_I);
    endtask

    // Read result is presented one clock after the pointer is applied.
    always @(posedge CLK_I) rd_valid <= rd_issue;

    // Monitor: compare each presented read against the oldest queued expectation.
    always @(negedge CLK_I) begin
        rd_exp_t e;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL read: DMEM_O=0x%0h presented with no expected entry", DMEM_O);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("read[%0d]", e.ptr), {24'h0, DMEM_O}, {24'h0, e.data});
            end
        end
    end

    task automatic do_read(input logic [3:0] ptr);
        rd_exp_t e;
        e.ptr  = ptr;
        e.data = model[ptr];
        exp_q.push_back(e);
        READ_PTR_I = ptr;
        rd_issue   = 1'b1;
        tick();
        rd_issue   = 1'b0;
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (RW_TURN_O !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'h0, RW_TURN_O}, 32'h1);
    endtask

    task automatic do_write(input logic [3:0] ptr, input logic [7:0] data);
        wait_strobe($sformatf("strobe before write[%0d]", ptr));
        WRITE_I     = 1'b1;
        WRITE_PTR_I = ptr;
        DMEM_I      = data;
        tick();
        WRITE_I     = 1'b0;
        model[ptr]  = data;
    endtask

    task automatic busy_count(input string name, input int expected);
        int n = 0;
        while (BUSY_O === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, n, expected);
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    initial begin
        RST_I       = 1'b1;
        ENABLE_I    = 1'b1;
        CLEAR_I     = 1'b0;
        WRITE_I     = 1'b0;
        WRITE_PTR_I = '0;
        READ_PTR_I  = '0;
        DMEM_I      = '0;
        zero_model();
        tick(3);

        // Reset state
        check("reset RW_TURN_O", {31'h0, RW_TURN_O}, 32'h0);
        check("reset WRITE_ALLOW_O", {31'h0, WRITE_ALLOW_O}, 32'h0);
        check("reset READ_ALLOW_O", {31'h0, READ_ALLOW_O}, 32'h0);
        check("reset DMEM_O", {24'h0, DMEM_O}, 32'h0);
        check("reset BUSY_O", {31'h0, BUSY_O}, 32'h1);
        check("reset PARITY_ERR_O", {31'h0, PARITY_ERR_O}, 32'h0);

        // Sweep after reset release, then strobe cadence
        RST_I = 1'b0;
        busy_count("sweep cycles after reset", 16);
        check("run READ_ALLOW_O", {31'h0, READ_ALLOW_O}, 32'h1);
        check("run WRITE_ALLOW_O", {31'h0, WRITE_ALLOW_O}, 32'h1);
        check("strobe at run entry", {31'h0, RW_TURN_O}, 32'h0);
        tick();
        check("strobe cycle 1", {31'h0, RW_TURN_O}, 32'h0);
        tick();
        check("strobe cycle 2", {31'h0, RW_TURN_O}, 32'h1);
        tick();
        check("strobe cycle 3", {31'h0, RW_TURN_O}, 32'h0);
        tick();
        check("strobe cycle 4", {31'h0, RW_TURN_O}, 32'h1);

        // All words zero after the sweep
        for (int i = 0; i < DEPTH; i++) do_read(4'(i));

        // Strobed write and read-back
        do_write(4'd3, 8'hA5);
        do_read(4'd3);

        // Write intent outside a strobe slot is ignored
        wait_strobe("strobe before stray write");
        tick();
        check("stray write off-strobe", {31'h0, RW_TURN_O}, 32'h0);
        WRITE_I     = 1'b1;
        WRITE_PTR_I = 4'd5;
        DMEM_I      = 8'hFF;
        tick();
        WRITE_I     = 1'b0;
        do_read(4'd5);

        // Top and bottom addresses
        do_write(4'd15, 8'h3C);
        do_write(4'd0, 8'hC3);
        do_read(4'd15);
        do_read(4'd0);
        do_read(4'd3);

        // Clear during RUN, then restart the sweep at address 7
        READ_PTR_I = 4'd3;
        CLEAR_I    = 1'b1;
        tick();
        CLEAR_I    = 1'b0;
        check("BUSY_O after clear request", {31'h0, BUSY_O}, 32'h1);
        tick(7);
        check("DMEM_O during sweep", {24'h0, DMEM_O}, 32'h0);
        check("READ_ALLOW_O during sweep", {31'h0, READ_ALLOW_O}, 32'h0);
        CLEAR_I = 1'b1;
        tick();
        CLEAR_I = 1'b0;
        busy_count("sweep cycles after restart", 16);
        zero_model();
        for (int i = 0; i < DEPTH; i++) do_read(4'(i));
        check("PARITY_ERR_O after clean sweep", {31'h0, PARITY_ERR_O}, 32'h0);

        // Disable for 5 cycles starting in a strobe slot
        wait_strobe("strobe before disable");
        ENABLE_I    = 1'b0;
        WRITE_I     = 1'b1;
        WRITE_PTR_I = 4'd6;
        DMEM_I      = 8'h5A;
        #1;
        check("WRITE_ALLOW_O on disable", {31'h0, WRITE_ALLOW_O}, 32'h0);
        check("registered strobe still high", {31'h0, RW_TURN_O}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("disabled strobe %0d", i), {31'h0, RW_TURN_O}, 32'h0);
            check($sformatf("disabled write allow %0d", i), {31'h0, WRITE_ALLOW_O}, 32'h0);
        end
        WRITE_I  = 1'b0;
        ENABLE_I = 1'b1;
        tick();
        check("re-enable cycle 1", {31'h0, RW_TURN_O}, 32'h0);
        tick();
        check("re-enable cycle 2", {31'h0, RW_TURN_O}, 32'h1);
        do_read(4'd6);

`ifdef TRB_MEM_PARITY_EN
        // Corrupt one stored bit and read it back
        do_write(4'd4, 8'h3C);
        dut.mem[4] = dut.mem[4] ^ 9'h001;
        model[4]   = 8'h3D;
        do_read(4'd4);
        check("parity error raised", {31'h0, PARITY_ERR_O}, 32'h1);
        READ_PTR_I = 4'd6;
        tick(3);
        check("parity error sticky", {31'h0, PARITY_ERR_O}, 32'h1);
        CLEAR_I = 1'b1;
        tick();
        CLEAR_I = 1'b0;
        check("parity error cleared", {31'h0, PARITY_ERR_O}, 32'h0);
        busy_count("sweep cycles after parity clear", 16);
        zero_model();
        do_read(4'd4);
`else
        tick(2);
        check("PARITY_ERR_O tied low", {31'h0, PARITY_ERR_O}, 32'h0);
`endif

        // Asynchronous reset in the middle of RUN
        do_write(4'd9, 8'h77);
        do_read(4'd9);
        #2;
        RST_I = 1'b1;
        #1;
        check("async reset BUSY_O", {31'h0, BUSY_O}, 32'h1);
        check("async reset READ_ALLOW_O", {31'h0, READ_ALLOW_O}, 32'h0);
        check("async reset WRITE_ALLOW_O", {31'h0, WRITE_ALLOW_O}, 32'h0);
        check("async reset DMEM_O", {24'h0, DMEM_O}, 32'h0);
        tick();
        RST_I = 1'b0;
        busy_count("sweep cycles after async reset", 16);
        zero_model();
        do_read(4'd9);

        tick(2);
        check("read queue drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
